// File: rtl/rtc_pkg.sv
// Shared definitions for the time-of-day keeper.
//   FLD_*          : bit index of each field in the per-field set vectors
//   DEF_*_MOD      : default moduli for seconds, minutes and hours
//   inc_mod()      : modulo increment used to predict the post-tick time
//   hour_24_to_12(): 24-hour to 12-hour display conversion (0 -> 12)
package rtc_pkg;

   localparam int FLD_SEC  = 0;
   localparam int FLD_MIN  = 1;
   localparam int FLD_HOUR = 2;

   localparam int DEF_SEC_MOD  = 60;
   localparam int DEF_MIN_MOD  = 60;
   localparam int DEF_HOUR_MOD = 24;

   function automatic int unsigned inc_mod(input int unsigned v, input int unsigned m);
      return (v == m - 1) ? 0 : v + 1;
   endfunction

   function automatic int unsigned hour_24_to_12(input int unsigned h);
      if (h == 0)
         return 12;
      else if (h > 12)
         return h - 12;
      else
         return h;
   endfunction

endpackage

// File: rtl/mod_field_counter.sv
// One time field as a modulo-MOD counter.
//   clk, rst   : clock, synchronous active-high reset (loads RESET_VALUE)
//   carry_in   : advance by one (tick or carry from the lower field)
//   inc, dec   : manual +1 / -1 for this field, applied only with cmd_valid
//   cmd_valid  : some manual set is active this cycle; carry_in is ignored
//   value      : current field value, always within 0..MOD-1
//   carry_out  : carry_in && value == MOD-1 (combinational)
module mod_field_counter
   import rtc_pkg::*;
#(
   parameter int W           = 8,
   parameter int MOD         = 60,
   parameter int RESET_VALUE = 0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         carry_in,
   input  logic         inc,
   input  logic         dec,
   input  logic         cmd_valid,
   output logic [W-1:0] value,
   output logic         carry_out
);

   localparam logic [W-1:0] MAX_VAL = W'(MOD - 1);
   localparam logic [W-1:0] RST_VAL = W'(RESET_VALUE);

   logic [W-1:0] value_up;
   logic [W-1:0] value_dn;

   assign value_up  = (value == MAX_VAL) ? '0 : value + 1'b1;
   assign value_dn  = (value == '0) ? MAX_VAL : value - 1'b1;
   assign carry_out = carry_in && (value == MAX_VAL);

   // NOTE: state registers use non-blocking assignments so every field
   // samples the others' pre-edge values and the cascade updates on one edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         value <= RST_VAL;
      end else if (cmd_valid) begin
         // Manual set never consumes carry_in; inc and dec together cancel.
         if (inc && !dec)
            value <= value_up;
         else if (dec && !inc)
            value <= value_dn;
      end else if (carry_in) begin
         value <= value_up;
      end
   end

endmodule

// File: rtl/rtc_timekeeper.sv
// Fully synchronous time-of-day keeper with prescaler, manual set,
// 12/24-hour display view, day rollover pulse and latched alarm.
//   clk, rst          : clock, synchronous active-high reset
//   en                : run enable; 0 freezes prescaler and time
//   signal_increase   : per-field +1 pulse, [0]=sec [1]=min [2]=hour
//   signal_decrease   : per-field -1 pulse, same indexing
//   mode_12h          : select 12-hour display view
//   alarm_en          : alarm armed; 0 also clears alarm_ring
//   alarm_hour/minute : alarm time (24-hour encoding, second is 0)
//   alarm_ack         : clears alarm_ring
//   cur_second/minute/hour : raw time fields
//   disp_hour, pm     : display hour and pm flag
//   day_tick          : one-cycle pulse after the hour wraps by carry
//   alarm_ring        : latched alarm indication
module rtc_timekeeper
   import rtc_pkg::*;
#(
   parameter int TICK_CYCLES = 25_000_000,
   parameter int W           = 8,
   parameter int SEC_MOD     = DEF_SEC_MOD,
   parameter int MIN_MOD     = DEF_MIN_MOD,
   parameter int HOUR_MOD    = DEF_HOUR_MOD,
   parameter int RESET_HOUR  = 8,
   parameter int RESET_MIN   = 0,
   parameter int RESET_SEC   = 0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic [2:0]   signal_increase,
   input  logic [2:0]   signal_decrease,
   input  logic         mode_12h,
   input  logic         alarm_en,
   input  logic [W-1:0] alarm_hour,
   input  logic [W-1:0] alarm_minute,
   input  logic         alarm_ack,
   output logic [W-1:0] cur_second,
   output logic [W-1:0] cur_minute,
   output logic [W-1:0] cur_hour,
   output logic [W-1:0] disp_hour,
   output logic         pm,
   output logic         day_tick,
   output logic         alarm_ring
);

   localparam int CNT_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_CYCLES - 1);

   logic [CNT_W-1:0] presc_cnt;
   logic             tick;
   logic             set_any;
   logic             tick_eff;
   logic             sec_carry;
   logic             min_carry;
   logic             hour_carry;
   logic [W-1:0]     next_minute;
   logic [W-1:0]     next_hour;
   logic             alarm_hit;

   assign set_any  = |{signal_increase, signal_decrease};
   assign tick     = en && (presc_cnt == CNT_LAST);
   // A manual set discards this cycle's tick so the second restarts cleanly.
   assign tick_eff = tick && !set_any;

   always_ff @(posedge clk) begin
      if (rst || set_any)
         presc_cnt <= '0;
      else if (en)
         presc_cnt <= tick ? '0 : presc_cnt + 1'b1;
   end

   mod_field_counter #(.W(W), .MOD(SEC_MOD), .RESET_VALUE(RESET_SEC)) u_sec (
      .clk       (clk),
      .rst       (rst),
      .carry_in  (tick_eff),
      .inc       (signal_increase[FLD_SEC]),
      .dec       (signal_decrease[FLD_SEC]),
      .cmd_valid (set_any),
      .value     (cur_second),
      .carry_out (sec_carry)
   );

   mod_field_counter #(.W(W), .MOD(MIN_MOD), .RESET_VALUE(RESET_MIN)) u_min (
      .clk       (clk),
      .rst       (rst),
      .carry_in  (sec_carry),
      .inc       (signal_increase[FLD_MIN]),
      .dec       (signal_decrease[FLD_MIN]),
      .cmd_valid (set_any),
      .value     (cur_minute),
      .carry_out (min_carry)
   );

   mod_field_counter #(.W(W), .MOD(HOUR_MOD), .RESET_VALUE(RESET_HOUR)) u_hour (
      .clk       (clk),
      .rst       (rst),
      .carry_in  (min_carry),
      .inc       (signal_increase[FLD_HOUR]),
      .dec       (signal_decrease[FLD_HOUR]),
      .cmd_valid (set_any),
      .value     (cur_hour),
      .carry_out (hour_carry)
   );

   // Predict the post-tick minute/hour; the post-tick second is 0 exactly
   // when the seconds field wraps, so sec_carry stands in for that match.
   assign next_minute = sec_carry ? W'(inc_mod(32'(cur_minute), MIN_MOD)) : cur_minute;
   assign next_hour   = min_carry ? W'(inc_mod(32'(cur_hour), HOUR_MOD)) : cur_hour;
   assign alarm_hit   = alarm_en && sec_carry &&
                        (next_minute == alarm_minute) && (next_hour == alarm_hour);

   always_ff @(posedge clk) begin
      if (rst) begin
         day_tick   <= 1'b0;
         alarm_ring <= 1'b0;
      end else begin
         day_tick <= hour_carry;
         // A hit outranks a simultaneous acknowledge.
         if (alarm_hit)
            alarm_ring <= 1'b1;
         else if (alarm_ack || !alarm_en)
            alarm_ring <= 1'b0;
      end
   end

   // NOTE: combinational outputs get their default first so no path
   // through the block leaves them unassigned and infers a latch.
   always_comb begin
      disp_hour = cur_hour;
      pm        = 1'b0;
      if (mode_12h) begin
         disp_hour = W'(hour_24_to_12(32'(cur_hour)));
         pm        = (cur_hour >= W'(12));
      end
   end

endmodule

// File: tb/tb_rtc_timekeeper.sv
// Self-checking bench for rtc_timekeeper with TICK_CYCLES=4.
module tb_rtc_timekeeper;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         en;
   logic [2:0]   signal_increase;
   logic [2:0]   signal_decrease;
   logic         mode_12h;
   logic         alarm_en;
   logic [W-1:0] alarm_hour;
   logic [W-1:0] alarm_minute;
   logic         alarm_ack;
   logic [W-1:0] cur_second;
   logic [W-1:0] cur_minute;
   logic [W-1:0] cur_hour;
   logic [W-1:0] disp_hour;
   logic         pm;
   logic         day_tick;
   logic         alarm_ring;

   rtc_timekeeper #(.TICK_CYCLES(4), .W(W)) dut (
      .clk             (clk),
      .rst             (rst),
      .en              (en),
      .signal_increase (signal_increase),
      .signal_decrease (signal_decrease),
      .mode_12h        (mode_12h),
      .alarm_en        (alarm_en),
      .alarm_hour      (alarm_hour),
      .alarm_minute    (alarm_minute),
      .alarm_ack       (alarm_ack),
      .cur_second      (cur_second),
      .cur_minute      (cur_minute),
      .cur_hour        (cur_hour),
      .disp_hour       (disp_hour),
      .pm              (pm),
      .day_tick        (day_tick),
      .alarm_ring      (alarm_ring)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [31:0] value;
   } exp_t;

   exp_t exp_q[$];
   int   errors = 0;
   int   checks = 0;

   function automatic logic [31:0] hms(input int h, input int m, input int s);
      return {8'h00, 8'(h), 8'(m), 8'(s)};
   endfunction

   function automatic logic [31:0] now_hms();
      return {8'h00, cur_hour, cur_minute, cur_second};
   endfunction

   task automatic push_exp(input string name, input logic [31:0] value);
      exp_q.push_back('{name, value});
   endtask

   task automatic tick_n(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_pulse(input logic [2:0] inc, input logic [2:0] dec);
      signal_increase = inc;
      signal_decrease = dec;
      tick_n(1);
      signal_increase = 3'b000;
      signal_decrease = 3'b000;
   endtask

   task automatic test_reset();
      exp_t e;
      logic [31:0] got;
      rst = 1'b1;
      push_exp("reset_time", hms(8, 0, 0));
      push_exp("reset_day_tick", 32'd0);
      push_exp("reset_ring", 32'd0);
      tick_n(2);
      rst = 1'b0;
      got = now_hms(); e = exp_q.pop_front(); checks++;
      if (got !== e.value) begin errors++; $display("FAIL %s: got %h expected %h", e.name, got, e.value); end
      got = 32'(day_tick); e = exp_q.pop_front(); checks++;
      if (got !== e.value) begin errors++; $display("FAIL %s: got %h expected %h", e.name, got, e.value); end
      got = 32'(alarm_ring); e = exp_q.pop_front(); checks++;
      if (got !== e.value) begin errors++; $display("FAIL %s: got %h expected %h", e.name, got, e.value); end
   endtask

   task automatic test_run_freeze();
      exp_t e;
      logic [31:0] got;
      en = 1'b1;
      push_exp("run_4_cycles", hms(8, 0, 1));
      tick_n(4);
      got = now_hms(); e = exp_q.pop_front(); checks++;
      if (got !== e.value) begin errors++; $display("FAIL %s: got %h expected %h", e.name, got, e.value); end
      push_exp("run_8_cycles", hms(8, 0, 2));
      tick_n(4);
      got = now_hms(); e = exp_q.pop_front(); checks++;
      if (got !== e.value) begin errors++; $display("FAIL %s: got %h expected %h", e.name, got, e.value); end
      en = 1'b0;
      push_exp("frozen_20_cycles", hms(8, 0, 2));
      tick_n(20);
      got = now_hms(); e = exp_q.pop_front(); checks++;
      if (got !== e.value) begin errors++; $display("FAIL %s: got %h expected %h", e.name, got, e.value); end
   endtask

   task automatic test_day_rollover();
      exp_t e;
      logic [31:0] got;
      // 08:00:02 -> 23:59:59 : hour -9, minute -1, second -3
      for (int i = 0; i < 9; i++)
         set_pulse(3'b000, {1'(i < 9), 1'(i < 1), 1'(i < 3)});
      push_exp("preset_235959", hms(23, 59, 59));
      got = now_hms(); e = exp_q.pop_front(); checks++;
      if (got !== e.value) begin errors++; $display("FAIL %s: got %h expected %h", e.name, got, e.value); end
      en = 1'b1;
      push_exp("before_tick_day_tick", 32'd0);
      tick_n(3);
      got = 32'(day_tick); e = exp_q.pop_front(); checks++;
      if (got !== e.value) begin errors++; $display("FAIL %s: got %h expected %h", e.name, got, e.value); end
      push_exp("wrap_to_000000", hms(0, 0, 0));
      push_exp("day_tick_high", 32'd1);
      tick_n(1);
      got = now_hms(); e = exp_q.pop_front(); checks++;
      if (got !== e.value) begin errors++; $display("FAIL %s: got %h expected %h", e.name, got, e.value); end
      got = 32'(day_tick); e = exp_q.pop_front(); checks++;
      if (got !== e.value) begin errors++; $display("FAIL %s: got %h expected %h", e.name, got, e.value); end
      push_exp("day_tick_one_cycle", 32'd0);
      tick_n(1);
      en = 1'b0;
      got = 32'(day_tick); e = exp_q.pop_front(); checks++;
      if (got !== e.value) begin errors++; $display("FAIL %s: got %h expected %h", e.name, got, e.value); end
   endtask

   task automatic test_manual_set();
      exp_t e;
      logic [31:0] got;
      push_exp("dec_sec_at_0", hms(0, 0, 59));
      set_pulse(3'b000, 3'b001);
      got = now_hms(); e = exp_q.pop_front(); checks++;
      if (got !== e.value) begin errors++; $display("FAIL %s: got %h expected %h", e.name, got, e.value); end
      push_exp("inc_dec_hour_cancel", hms(0, 0, 59));
      set_pulse(3'b100, 3'b100);
      got = now_hms(); e = exp_q.pop_front(); checks++;
      if (got !== e.value) begin errors++; $display("FAIL %s: got %h expected %h", e.name, got, e.value); end
      // Prescaler is at 0; three edges bring it to the tick cycle.
      en = 1'b1;
      tick_n(3);
      push_exp("inc_in_tick_cycle", hms(0, 0, 0));
      set_pulse(3'b001, 3'b000);
      got = now_hms(); e = exp_q.pop_front(); checks++;
      if (got !== e.value) begin errors++; $display("FAIL %s: got %h expected %h", e.name, got, e.value); end
      push_exp("no_tick_after_3", hms(0, 0, 0));
      tick_n(3);
      got = now_hms(); e = exp_q.pop_front(); checks++;
      if (got !== e.value) begin errors++; $display("FAIL %s: got %h expected %h", e.name, got, e.value); end
      push_exp("tick_after_4", hms(0, 0, 1));
      tick_n(1);
      en = 1'b0;
      got = now_hms(); e = exp_q.pop_front(); checks++;
      if (got !== e.value) begin errors++; $display("FAIL %s: got %h expected %h", e.name, got, e.value); end
   endtask

   task automatic test_alarm();
      exp_t e;
      logic [31:0] got;
      alarm_hour   = 8'd8;
      alarm_minute = 8'd1;
      alarm_en     = 1'b1;
      // 00:00:01 -> 08:00:59 : hour +8, second -2
      for (int i = 0; i < 8; i++)
         set_pulse(3'b100, {2'b00, 1'(i < 2)});
      push_exp("alarm_preset", hms(8, 0, 59));
      got = now_hms(); e = exp_q.pop_front(); checks++;
      if (got !== e.value) begin errors++; $display("FAIL %s: got %h expected %h", e.name, got, e.value); end
      en = 1'b1;
      push_exp("ring_before_hit", 32'd0);
      tick_n(3);
      got = 32'(alarm_ring); e = exp_q.pop_front(); checks++;
      if (got !== e.value) begin errors++; $display("FAIL %s: got %h expected %h", e.name, got, e.value); end
      push_exp("ring_at_hit", 32'd1);
      tick_n(1);
      en = 1'b0;
      got = 32'(alarm_ring); e = exp_q.pop_front(); checks++;
      if (got !== e.value) begin errors++; $display("FAIL %s: got %h expected %h", e.name, got, e.value); end
      push_exp("ring_after_ack", 32'd0);
      alarm_ack = 1'b1;
      tick_n(1);
      alarm_ack = 1'b0;
      got = 32'(alarm_ring); e = exp_q.pop_front(); checks++;
      if (got !== e.value) begin errors++; $display("FAIL %s: got %h expected %h", e.name, got, e.value); end
      // Land on 08:01:00 by manual set: 08:01:00 -> 08:00:00 -> 08:01:00
      set_pulse(3'b000, 3'b010);
      push_exp("manual_set_time", hms(8, 1, 0));
      push_exp("manual_set_no_ring", 32'd0);
      set_pulse(3'b010, 3'b000);
      got = now_hms(); e = exp_q.pop_front(); checks++;
      if (got !== e.value) begin errors++; $display("FAIL %s: got %h expected %h", e.name, got, e.value); end
      got = 32'(alarm_ring); e = exp_q.pop_front(); checks++;
      if (got !== e.value) begin errors++; $display("FAIL %s: got %h expected %h", e.name, got, e.value); end
      // Hit in the same cycle as ack: ring stays set.
      set_pulse(3'b000, 3'b011);
      en = 1'b1;
      tick_n(3);
      alarm_ack = 1'b1;
      push_exp("hit_beats_ack", 32'd1);
      tick_n(1);
      alarm_ack = 1'b0;
      en = 1'b0;
      got = 32'(alarm_ring); e = exp_q.pop_front(); checks++;
      if (got !== e.value) begin errors++; $display("FAIL %s: got %h expected %h", e.name, got, e.value); end
      alarm_en = 1'b0;
      push_exp("disarm_clears_ring", 32'd0);
      tick_n(1);
      got = 32'(alarm_ring); e = exp_q.pop_front(); checks++;
      if (got !== e.value) begin errors++; $display("FAIL %s: got %h expected %h", e.name, got, e.value); end
   endtask

   task automatic test_12h_view();
      exp_t e;
      logic [31:0] got;
      for (int i = 0; i < 8; i++)
         set_pulse(3'b000, 3'b100);
      mode_12h = 1'b1;
      #1;
      push_exp("h00_disp_pm", {16'h0, 8'd12, 8'd0});
      got = {16'h0, disp_hour, 7'd0, pm}; e = exp_q.pop_front(); checks++;
      if (got !== e.value) begin errors++; $display("FAIL %s: got %h expected %h", e.name, got, e.value); end
      for (int i = 0; i < 12; i++)
         set_pulse(3'b100, 3'b000);
      push_exp("h12_disp_pm", {16'h0, 8'd12, 8'd1});
      got = {16'h0, disp_hour, 7'd0, pm}; e = exp_q.pop_front(); checks++;
      if (got !== e.value) begin errors++; $display("FAIL %s: got %h expected %h", e.name, got, e.value); end
      for (int i = 0; i < 11; i++)
         set_pulse(3'b100, 3'b000);
      push_exp("h23_disp_pm", {16'h0, 8'd11, 8'd1});
      got = {16'h0, disp_hour, 7'd0, pm}; e = exp_q.pop_front(); checks++;
      if (got !== e.value) begin errors++; $display("FAIL %s: got %h expected %h", e.name, got, e.value); end
      push_exp("h23_raw_hour", 32'd23);
      got = 32'(cur_hour); e = exp_q.pop_front(); checks++;
      if (got !== e.value) begin errors++; $display("FAIL %s: got %h expected %h", e.name, got, e.value); end
      mode_12h = 1'b0;
      #1;
      push_exp("h23_24h_view", {16'h0, 8'd23, 8'd0});
      got = {16'h0, disp_hour, 7'd0, pm}; e = exp_q.pop_front(); checks++;
      if (got !== e.value) begin errors++; $display("FAIL %s: got %h expected %h", e.name, got, e.value); end
   endtask

   task automatic test_reset_midcount();
      exp_t e;
      logic [31:0] got;
      alarm_hour   = 8'd15;
      alarm_minute = 8'd30;
      alarm_en     = 1'b1;
      // 23:01:00 -> 15:29:59 : hour -8, minute +28, second -1
      for (int i = 0; i < 28; i++)
         set_pulse({2'b00, 1'(i < 28)} << 1, {1'(i < 8), 1'b0, 1'(i < 1)});
      en = 1'b1;
      tick_n(4);
      en = 1'b0;
      for (int i = 0; i < 45; i++)
         set_pulse(3'b001, 3'b000);
      push_exp("pre_reset_time", hms(15, 30, 45));
      push_exp("pre_reset_ring", 32'd1);
      got = now_hms(); e = exp_q.pop_front(); checks++;
      if (got !== e.value) begin errors++; $display("FAIL %s: got %h expected %h", e.name, got, e.value); end
      got = 32'(alarm_ring); e = exp_q.pop_front(); checks++;
      if (got !== e.value) begin errors++; $display("FAIL %s: got %h expected %h", e.name, got, e.value); end
      en = 1'b1;
      tick_n(2);
      rst = 1'b1;
      push_exp("mid_reset_time", hms(8, 0, 0));
      push_exp("mid_reset_ring", 32'd0);
      tick_n(1);
      rst = 1'b0;
      got = now_hms(); e = exp_q.pop_front(); checks++;
      if (got !== e.value) begin errors++; $display("FAIL %s: got %h expected %h", e.name, got, e.value); end
      got = 32'(alarm_ring); e = exp_q.pop_front(); checks++;
      if (got !== e.value) begin errors++; $display("FAIL %s: got %h expected %h", e.name, got, e.value); end
      // A cleared prescaler needs a full four cycles for the next tick.
      push_exp("post_reset_3", hms(8, 0, 0));
      tick_n(3);
      got = now_hms(); e = exp_q.pop_front(); checks++;
      if (got !== e.value) begin errors++; $display("FAIL %s: got %h expected %h", e.name, got, e.value); end
      push_exp("post_reset_4", hms(8, 0, 1));
      tick_n(1);
      en = 1'b0;
      got = now_hms(); e = exp_q.pop_front(); checks++;
      if (got !== e.value) begin errors++; $display("FAIL %s: got %h expected %h", e.name, got, e.value); end
   endtask

   initial begin
      rst             = 1'b1;
      en              = 1'b0;
      signal_increase = 3'b000;
      signal_decrease = 3'b000;
      mode_12h        = 1'b0;
      alarm_en        = 1'b0;
      alarm_hour      = '0;
      alarm_minute    = '0;
      alarm_ack       = 1'b0;
      test_reset();
      test_run_freeze();
      test_day_rollover();
      test_manual_set();
      test_alarm();
      test_12h_view();
      test_reset_midcount();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
